// File: rtl/barrel_shifter_pipelined.sv
// Pipelined barrel shifter: LSL/LSR/ASL/ASR/ROL/ROR/RLC/RRC at any power-of-2 width.
// Latency: STAGES advancing edges, the acceptance edge included; one operand per cycle.
// Backpressure: the whole pipeline stalls as one unit when the held result is not taken or Enable_In is low.
module barrel_shifter_pipelined #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = $clog2(DATA_WIDTH)
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  input  logic [2:0]            Shifter_Mode_In,
  input  logic [STAGES-1:0]     Shift_Bits_Length_In,
  input  logic                  Carry_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic                  Valid_Out,
  input  logic                  Ready_In,
  output logic [DATA_WIDTH-1:0] Shifted_Data_Out,
  output logic                  Carry_Out,
  output logic                  Overflow_Out,
  output logic                  Zero_Out
);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASL = 3'd2;
  localparam logic [2:0] MODE_ASR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;
  localparam logic [2:0] MODE_ROR = 3'd5;
  localparam logic [2:0] MODE_RLC = 3'd6;
  localparam logic [2:0] MODE_RRC = 3'd7;

  localparam int LAST = STAGES - 1;

  // Per-stage result registers; every stage owns one of these.
  logic                  vld_q   [STAGES];
  logic [DATA_WIDTH-1:0] data_q  [STAGES];
  logic                  carry_q [STAGES];
  logic                  ovf_q   [STAGES];

  // Side-band that travels with the operand. The last stage needs no copy
  // because nothing downstream consumes mode, amount or original MSB.
  logic [2:0]            mode_q  [STAGES-1];
  logic [STAGES-1:0]     amt_q   [STAGES-1];
  logic                  msb_q   [STAGES-1];

  // Inputs seen by each stage: the block ports for stage 0, the previous
  // stage's registers otherwise. Amount is kept LSB-aligned so that every
  // stage looks only at bit 0 of what it receives.
  logic                  src_vld   [STAGES];
  logic [2:0]            src_mode  [STAGES];
  logic [STAGES-1:0]     src_amt   [STAGES];
  logic [DATA_WIDTH-1:0] src_data  [STAGES];
  logic                  src_carry [STAGES];
  logic                  src_ovf   [STAGES];
  logic                  src_msb   [STAGES];

  // Next-state values produced by each stage's shift network.
  logic [DATA_WIDTH-1:0] data_d  [STAGES];
  logic                  carry_d [STAGES];
  logic                  ovf_d   [STAGES];

  logic advance;

  // The pipeline moves only when enabled and the output slot is free or being drained.
  assign advance   = Enable_In & (Ready_In | ~vld_q[LAST]);
  assign Ready_Out = advance;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int SH = 1 << i;

    if (i == 0) begin : g_src_in
      assign src_vld[i]   = Valid_In;
      assign src_mode[i]  = Shifter_Mode_In;
      assign src_amt[i]   = Shift_Bits_Length_In;
      assign src_data[i]  = Data_In;
      assign src_carry[i] = Carry_In;
      assign src_ovf[i]   = 1'b0;
      assign src_msb[i]   = Data_In[DATA_WIDTH-1];
    end else begin : g_src_prev
      assign src_vld[i]   = vld_q[i-1];
      assign src_mode[i]  = mode_q[i-1];
      assign src_amt[i]   = amt_q[i-1];
      assign src_data[i]  = data_q[i-1];
      assign src_carry[i] = carry_q[i-1];
      assign src_ovf[i]   = ovf_q[i-1];
      assign src_msb[i]   = msb_q[i-1];
    end

    logic [DATA_WIDTH-1:0] stg_data;
    logic                  stg_carry;
    logic                  stg_ovf;
    logic [DATA_WIDTH:0]   stg_vec;
    logic [DATA_WIDTH:0]   stg_rot;
    logic [SH-1:0]         stg_out_bits;

    // Shift by the fixed distance SH when this stage's amount bit is set.
    // Carry is overwritten only by a stage that actually shifts, so the
    // last shifting stage leaves the correct final carry behind.
    always_comb begin
      stg_data     = src_data[i];
      stg_carry    = src_carry[i];
      stg_ovf      = src_ovf[i];
      stg_vec      = {src_carry[i], src_data[i]};
      stg_rot      = stg_vec;
      stg_out_bits = src_data[i][DATA_WIDTH-1 -: SH];
      if (src_amt[i][0]) begin
        case (src_mode[i])
          MODE_LSL, MODE_ASL: begin
            stg_data  = {src_data[i][DATA_WIDTH-1-SH:0], {SH{1'b0}}};
            stg_carry = src_data[i][DATA_WIDTH-SH];
          end
          MODE_LSR: begin
            stg_data  = {{SH{1'b0}}, src_data[i][DATA_WIDTH-1:SH]};
            stg_carry = src_data[i][SH-1];
          end
          MODE_ASR: begin
            // The current MSB is still the original MSB, ASR never changes it.
            stg_data  = {{SH{src_data[i][DATA_WIDTH-1]}}, src_data[i][DATA_WIDTH-1:SH]};
            stg_carry = src_data[i][SH-1];
          end
          MODE_ROL: begin
            stg_data  = {src_data[i][DATA_WIDTH-1-SH:0], src_data[i][DATA_WIDTH-1 -: SH]};
            stg_carry = src_data[i][DATA_WIDTH-SH];
          end
          MODE_ROR: begin
            stg_data  = {src_data[i][SH-1:0], src_data[i][DATA_WIDTH-1:SH]};
            stg_carry = src_data[i][SH-1];
          end
          MODE_RLC: begin
            stg_rot   = {stg_vec[DATA_WIDTH-SH:0], stg_vec[DATA_WIDTH -: SH]};
            stg_data  = stg_rot[DATA_WIDTH-1:0];
            stg_carry = stg_rot[DATA_WIDTH];
          end
          MODE_RRC: begin
            stg_rot   = {stg_vec[SH-1:0], stg_vec[DATA_WIDTH:SH]};
            stg_data  = stg_rot[DATA_WIDTH-1:0];
            stg_carry = stg_rot[DATA_WIDTH];
          end
          default: begin
            stg_data  = src_data[i];
            stg_carry = src_carry[i];
          end
        endcase
        // ASL overflow: every bit leaving the top, and every bit landing in
        // the MSB, must match the operand's original sign bit.
        if (src_mode[i] == MODE_ASL) begin
          if ((stg_out_bits != {SH{src_msb[i]}}) || (stg_data[DATA_WIDTH-1] != src_msb[i])) begin
            stg_ovf = 1'b1;
          end
        end
      end
    end

    assign data_d[i]  = stg_data;
    assign carry_d[i] = stg_carry;
    assign ovf_d[i]   = stg_ovf;
  end

  // Advance every stage together; reset discards all in-flight operands.
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]   <= 1'b0;
        data_q[i]  <= '0;
        carry_q[i] <= 1'b0;
        ovf_q[i]   <= 1'b0;
      end
      for (int i = 0; i < STAGES - 1; i++) begin
        mode_q[i] <= '0;
        amt_q[i]  <= '0;
        msb_q[i]  <= 1'b0;
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]   <= src_vld[i];
        data_q[i]  <= data_d[i];
        carry_q[i] <= carry_d[i];
        ovf_q[i]   <= ovf_d[i];
      end
      for (int i = 0; i < STAGES - 1; i++) begin
        mode_q[i] <= src_mode[i];
        amt_q[i]  <= src_amt[i] >> 1;
        msb_q[i]  <= src_msb[i];
      end
    end
  end

  assign Valid_Out        = vld_q[LAST];
  assign Shifted_Data_Out = data_q[LAST];
  assign Carry_Out        = carry_q[LAST];
  assign Overflow_Out     = ovf_q[LAST];
  // Qualified by valid so that an empty pipeline never reports a zero result.
  assign Zero_Out         = vld_q[LAST] & (data_q[LAST] == '0);

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
// Bench for barrel_shifter_pipelined at DATA_WIDTH=8.
// Bit-serial reference model plus queue scoreboard, checked every cycle.
// Directed vectors pin literal results, latency, stalls and mid-flight reset.
module tb_barrel_shifter_pipelined;
  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n, en, vin, rdy_in, cin;
  logic [2:0]   mode;
  logic [S-1:0] amt;
  logic [W-1:0] din;
  logic         Ready_Out, Valid_Out, Carry_Out, Overflow_Out, Zero_Out;
  logic [W-1:0] Shifted_Data_Out;

  always #5 clk = ~clk;

  barrel_shifter_pipelined #(.DATA_WIDTH(W)) dut (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en), .Valid_In(vin),
    .Ready_Out(Ready_Out), .Shifter_Mode_In(mode), .Shift_Bits_Length_In(amt),
    .Carry_In(cin), .Data_In(din), .Valid_Out(Valid_Out), .Ready_In(rdy_in),
    .Shifted_Data_Out(Shifted_Data_Out), .Carry_Out(Carry_Out),
    .Overflow_Out(Overflow_Out), .Zero_Out(Zero_Out)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         o;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   age_q[$];
  res_t got_q[$];
  res_t seq1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: apply the operation one bit position at a time.
  function automatic res_t model(input logic [2:0] m, input int n, input logic ci, input logic [W-1:0] di);
    res_t r;
    logic [W-1:0] d;
    logic c, o, msb, t;
    d = di; c = ci; o = 1'b0; msb = di[W-1];
    for (int k = 0; k < n; k++) begin
      case (m)
        3'd0, 3'd2: begin
          c = d[W-1];
          if (m == 3'd2 && c != msb) o = 1'b1;
          d = {d[W-2:0], 1'b0};
        end
        3'd1: begin c = d[0]; d = {1'b0, d[W-1:1]}; end
        3'd3: begin c = d[0]; d = {d[W-1], d[W-1:1]}; end
        3'd4: begin d = {d[W-2:0], d[W-1]}; c = d[0]; end
        3'd5: begin d = {d[0], d[W-1:1]}; c = d[W-1]; end
        3'd6: begin t = d[W-1]; d = {d[W-2:0], c}; c = t; end
        default: begin t = d[0]; d = {c, d[W-1:1]}; c = t; end
      endcase
    end
    if (m == 3'd2 && d[W-1] != msb) o = 1'b1;
    r.d = d; r.c = c; r.o = o;
    return r;
  endfunction

  // Scoreboard: each accepted operand ages by one per advancing edge and is
  // due on the output once it has seen S advancing edges.
  always @(negedge clk) begin
    logic ev, adv;
    if (!rst_n) begin
      exp_q.delete();
      age_q.delete();
      chk("rst_valid", 32'(Valid_Out), 32'd0);
      chk("rst_data", 32'(Shifted_Data_Out), 32'd0);
      chk("rst_flags", 32'({Carry_Out, Overflow_Out, Zero_Out}), 32'd0);
    end else begin
      ev = (exp_q.size() > 0) ? (age_q[0] == S) : 1'b0;
      chk("valid_out", 32'(Valid_Out), 32'(ev));
      adv = en & (rdy_in | ~ev);
      chk("ready_out", 32'(Ready_Out), 32'(adv));
      if (ev) begin
        chk("data", 32'(Shifted_Data_Out), 32'(exp_q[0].d));
        chk("carry", 32'(Carry_Out), 32'(exp_q[0].c));
        chk("overflow", 32'(Overflow_Out), 32'(exp_q[0].o));
        chk("zero", 32'(Zero_Out), 32'(exp_q[0].d == '0));
      end
      if (adv) begin
        if (ev) begin
          got_q.push_back({Shifted_Data_Out, Carry_Out, Overflow_Out});
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        foreach (age_q[k]) age_q[k]++;
        if (vin) begin
          exp_q.push_back(model(mode, int'(amt), cin, din));
          age_q.push_back(1);
        end
      end
    end
  end

  // One operand into an idle pipeline; checks literal result and latency.
  // Entered and left at posedge+1.
  task automatic run_one(input string name, input logic [2:0] m, input logic [S-1:0] a,
                         input logic ci, input logic [W-1:0] di, input logic [W-1:0] ed,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    bit seen;
    mode = m; amt = a; cin = ci; din = di; vin = 1'b1;
    @(posedge clk); #1 vin = 1'b0;
    lat = 1; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (Valid_Out) seen = 1'b1;
      else begin @(posedge clk); #1 lat++; end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk(name, 32'({Shifted_Data_Out, Carry_Out, Overflow_Out, Zero_Out}), 32'({ed, ec, eo, ez}));
    chk({name, "_latency"}, 32'(lat), 32'(S));
    @(posedge clk); #1;
  endtask

  // Six back-to-back operands; stall_en=0 drops Ready_In for 3 cycles,
  // stall_en=1 drops Enable_In for 2 cycles, once the first result shows.
  logic [2:0]   st_mode [6] = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd2, 3'd5};
  logic [S-1:0] st_amt  [6] = '{3'd1, 3'd3, 3'd2, 3'd5, 3'd2, 3'd7};
  logic         st_cin  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] st_din  [6] = '{8'hA5, 8'hC4, 8'h96, 8'h3C, 8'h1F, 8'h81};

  task automatic stream(input bit stall_en);
    got_q.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int g;
          mode = st_mode[k]; amt = st_amt[k]; cin = st_cin[k]; din = st_din[k]; vin = 1'b1;
          g = 0;
          @(negedge clk);
          while (!Ready_Out && g < 50) begin @(negedge clk); g++; end
          if (!Ready_Out) chk("stream_accept_timeout", 32'd0, 32'd1);
          @(posedge clk); #1;
        end
        vin = 1'b0;
      end
      begin
        for (int g = 0; g < 50 && !Valid_Out; g++) @(negedge clk);
        if (!Valid_Out) chk("stream_first_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (stall_en) begin
          en = 1'b0;
          repeat (2) @(posedge clk);
          #1 en = 1'b1;
        end else begin
          rdy_in = 1'b0;
          repeat (3) @(posedge clk);
          #1 rdy_in = 1'b1;
        end
      end
    join
    for (int g = 0; g < 50 && got_q.size() < 6; g++) @(negedge clk);
    chk(stall_en ? "enable_stall_count" : "ready_stall_count", 32'(got_q.size()), 32'd6);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; vin = 1'b0; rdy_in = 1'b1; cin = 1'b0;
    mode = '0; amt = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(Valid_Out), 32'd0);
    chk("reset_outputs", 32'({Shifted_Data_Out, Carry_Out, Overflow_Out, Zero_Out}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("lsl_b3_3", 3'd0, 3'd3, 1'b0, 8'hB3, 8'h98, 1'b1, 1'b0, 1'b0);
    run_one("asr_96_2", 3'd3, 3'd2, 1'b0, 8'h96, 8'hE5, 1'b1, 1'b0, 1'b0);
    run_one("asl_40_1", 3'd2, 3'd1, 1'b0, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0);
    run_one("lsr_01_1", 3'd1, 3'd1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_one("rlc_81_1", 3'd6, 3'd1, 1'b0, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0);
    run_one("rrc_01_1", 3'd7, 3'd1, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
    run_one("ror_01_1", 3'd5, 3'd1, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
    run_one("rol_81_1", 3'd4, 3'd1, 1'b0, 8'h81, 8'h03, 1'b1, 1'b0, 1'b0);
    run_one("asl_c0_1", 3'd2, 3'd1, 1'b0, 8'hC0, 8'h80, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 8; m++) begin
      run_one($sformatf("amt0_mode%0d", m), 3'(m), 3'd0, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0);
    end

    stream(1'b0);
    seq1 = got_q;
    stream(1'b1);
    chk("seq_len", 32'(got_q.size()), 32'(seq1.size()));
    for (int k = 0; k < 6 && k < got_q.size() && k < seq1.size(); k++) begin
      chk($sformatf("seq_item%0d", k), 32'(got_q[k]), 32'(seq1[k]));
    end

    // Three operands in flight, then reset between clock edges.
    for (int k = 0; k < 3; k++) begin
      mode = 3'd0; amt = 3'd1; cin = 1'b0; din = 8'h81 + 8'(k); vin = 1'b1;
      @(posedge clk); #1;
    end
    vin = 1'b0;
    chk("pre_reset_valid", 32'(Valid_Out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(Valid_Out), 32'd0);
    chk("async_reset_outputs", 32'({Shifted_Data_Out, Carry_Out, Overflow_Out, Zero_Out}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(Valid_Out), 32'd0);
    run_one("post_reset_op", 3'd1, 3'd4, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
